// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program memory and PC sequencer feeding DIN/Run of a 16-bit bus processor
// Optional Done watchdog enabled by defining PROG_SEQUENCER_WDOG_EN.
module prog_sequencer #(
    parameter int          ADDR_W      = 6,
    parameter int          DATA_W      = 16,
    parameter logic [3:0]  MVI_OP      = 4'b0001,
    parameter logic [3:0]  HALT_OP     = 4'b1111,
    parameter int          WDOG_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              done,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       instr_count,
    output logic              fault
);
    localparam int DEPTH = 1 << ADDR_W;

    if (DATA_W < 4 || ADDR_W < 1 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("prog_sequencer: invalid parameters");
    end

`ifdef PROG_SEQUENCER_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_EXEC, S_HALTED, S_FAULT} state_t;
    logic [WD_W-1:0] wd_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_HALTED} state_t;
`endif

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] next_word;
    logic              cur_is_mvi;
    logic [ADDR_W-1:0] pc_step;
    logic              first_exec;

    // Memory is frozen while busy, so mem[pc] is a stable view of the current instruction.
    assign cur_word   = mem[pc];
    assign next_word  = mem[pc + ADDR_W'(1)];
    assign cur_is_mvi = (cur_word[3:0] == MVI_OP);
    assign pc_step    = cur_is_mvi ? ADDR_W'(2) : ADDR_W'(1);
    assign busy       = (state == S_ISSUE) || (state == S_EXEC);
    assign halted     = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            din         <= '0;
            run         <= 1'b0;
            instr_count <= '0;
            first_exec  <= 1'b0;
`ifdef PROG_SEQUENCER_WDOG_EN
            fault       <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_ISSUE: begin
                    if (cur_word[3:0] == HALT_OP) begin
                        run   <= 1'b0;
                        state <= S_HALTED;
                    end else begin
                        din        <= cur_word;
                        run        <= 1'b1;
                        first_exec <= 1'b1;
                        state      <= S_EXEC;
`ifdef PROG_SEQUENCER_WDOG_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                S_EXEC: begin
                    first_exec <= 1'b0;
                    // Swap in the immediate right after the processor has latched IR.
                    if (first_exec && din[3:0] == MVI_OP) begin
                        din <= next_word;
                    end
                    if (done) begin
                        pc    <= pc + pc_step;
                        state <= S_ISSUE;
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
`ifdef PROG_SEQUENCER_WDOG_EN
                    end else if (wd_cnt == WD_W'(WDOG_CYCLES - 1)) begin
                        run   <= 1'b0;
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
`endif
                    end
                end
                default: begin
                    if (start && !load_en) begin
                        pc    <= '0;
                        state <= S_ISSUE;
`ifdef PROG_SEQUENCER_WDOG_EN
                        fault <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

`ifndef PROG_SEQUENCER_WDOG_EN
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed bench for prog_sequencer with a small bus-processor model
module tb_prog_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic        done;
    logic [15:0] din;
    logic        run;
    logic [5:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;
    logic        fault;

    logic done_block = 1'b0;
    logic done_force = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .done        (done),
        .din         (din),
        .run         (run),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count),
        .fault       (fault)
    );

    // Processor model: opcode [3:0], X=[6:4], Y=[9:7]; 0 mv, 1 mvi, 2 add, 3 sub, others nop ALU.
    logic [15:0] r [8];
    logic [2:0]  ts;
    logic        gap;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [2:0]  need;
    logic        p_done;

    assign op     = ir[3:0];
    assign need   = (op == 4'd0) ? 3'd1 : (op == 4'd1) ? 3'd2 : 3'd3;
    assign p_done = run && !gap && ts != 3'd0 && ts >= need;
    assign done   = (p_done && !done_block) || done_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts  <= '0;
            gap <= 1'b0;
            ir  <= '0;
        end else if (!run) begin
            ts  <= '0;
            gap <= 1'b0;
        end else if (gap) begin
            gap <= 1'b0;
        end else if (ts == 3'd0) begin
            ir <= din;
            ts <= 3'd1;
        end else if (done) begin
            case (op)
                4'd0: r[ir[6:4]] <= r[ir[9:7]];
                4'd1: r[ir[6:4]] <= din;
                4'd2: r[ir[6:4]] <= r[ir[6:4]] + r[ir[9:7]];
                4'd3: r[ir[6:4]] <= r[ir[6:4]] - r[ir[9:7]];
                default: ;
            endcase
            ts  <= '0;
            gap <= 1'b1;
        end else if (ts != 3'd7) begin
            ts <= ts + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [5:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_halt(input int maxc, output int cyc, output int gaps);
        bit seen;
        seen = 0;
        cyc  = 0;
        gaps = 0;
        while (!halted && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (run) seen = 1;
            if (seen && busy && !run) gaps++;
        end
        check("reached_halt", halted, 1);
    endtask

    task automatic wait_pc(input logic [5:0] tgt, input int maxc);
        int n;
        n = 0;
        while (!(pc == tgt && busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("wait_pc", pc, tgt);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int gaps;
        int n;

        @(negedge clk);
        check("rst_run", run, 0);
        check("rst_pc", pc, 0);
        check("rst_din", din, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_count", instr_count, 0);
        check("rst_fault", fault, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // mvi R0,5 ; HALT (HALT written together with a Start that must be ignored)
        load(6'd0, 16'h0001);
        load(6'd1, 16'h0005);
        start = 1'b1; load_en = 1'b1; load_addr = 6'd2; load_data = 16'h000F;
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        check("start_with_load_ignored", busy, 0);
        pulse_start();
        @(negedge clk);
        check("p1_din_instr", din, 16'h0001);
        check("p1_run", run, 1);
        @(negedge clk);
        check("p1_din_imm", din, 16'h0005);
        run_to_halt(50, cyc, gaps);
        check("p1_cycles", cyc, 3);
        check("p1_r0", r[0], 16'h0005);
        check("p1_pc", pc, 2);
        check("p1_count", instr_count, 1);
        check("p1_run_off", run, 0);

        done_force = 1'b1;
        repeat (3) @(negedge clk);
        done_force = 1'b0;
        check("idle_done_pc", pc, 2);
        check("idle_done_count", instr_count, 1);
        check("idle_done_halted", halted, 1);

        // mvi R0,3 ; mvi R1,4 ; add R0,R1 ; HALT with load/start interference while busy
        do_reset();
        load(6'd0, 16'h0001);
        load(6'd1, 16'h0003);
        load(6'd2, 16'h0011);
        load(6'd3, 16'h0004);
        load(6'd4, 16'h0082);
        load(6'd5, 16'h000F);
        pulse_start();
        repeat (3) @(negedge clk);
        load_en = 1'b1; load_addr = 6'd4; load_data = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        run_to_halt(100, cyc, gaps);
        check("p2_cycles", cyc, 10);
        check("p2_run_gaps", gaps, 0);
        check("p2_r0", r[0], 16'h0007);
        check("p2_count", instr_count, 3);
        check("p2_pc", pc, 5);

        // reset in the middle of the add, then rerun
        pulse_start();
        wait_pc(6'd4, 50);
        @(negedge clk);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_run", run, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        run_to_halt(100, cyc, gaps);
        check("rerun_cycles", cyc, 14);
        check("rerun_r0", r[0], 16'h0007);
        check("rerun_count", instr_count, 3);

        // mvi at the last address takes its immediate from address 0
        do_reset();
        load(6'd0, 16'h00AA);
        for (int i = 1; i < 64; i++) begin
            if (i == 63)    load(6'(i), 16'h0021);
            else if (i % 2) load(6'(i), 16'h0031);
            else            load(6'(i), 16'(i));
        end
        pulse_start();
        wait_pc(6'd63, 300);
        @(negedge clk);
        check("wrap_din_instr", din, 16'h0021);
        @(negedge clk);
        check("wrap_din_imm", din, 16'h00AA);
        n = 0;
        while (pc == 6'd63 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("wrap_next_pc", pc, 1);
        check("wrap_count", instr_count, 33);
        check("wrap_r2", r[2], 16'h00AA);

        // Done withheld during an add
        do_reset();
        load(6'd0, 16'h0001);
        load(6'd1, 16'h0009);
        load(6'd2, 16'h0082);
        load(6'd3, 16'h000F);
        pulse_start();
        wait_pc(6'd2, 50);
        done_block = 1'b1;
        repeat (8) @(negedge clk);
        check("stall_fault_early", fault, 0);
        check("stall_run_early", run, 1);
        @(negedge clk);
`ifdef PROG_SEQUENCER_WDOG_EN
        check("wdog_fault", fault, 1);
        check("wdog_run", run, 0);
        check("wdog_pc", pc, 2);
        check("wdog_busy", busy, 0);
        pulse_start();
        check("wdog_clear", fault, 0);
        check("wdog_restart_pc", pc, 0);
        check("wdog_restart_busy", busy, 1);
        done_block = 1'b0;
        run_to_halt(100, cyc, gaps);
        check("wdog_final_pc", pc, 3);
`else
        check("stall_fault", fault, 0);
        check("stall_run", run, 1);
        check("stall_pc", pc, 2);
        repeat (20) @(negedge clk);
        check("stall_busy", busy, 1);
        done_block = 1'b0;
        run_to_halt(100, cyc, gaps);
        check("stall_final_pc", pc, 3);
        check("stall_count", instr_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Upstream instruction feeder for the 16-bit bus processor.
- Holds a small writable program memory and walks a program counter (PC).
- Drives the processor's DIN and Run inputs and consumes its Done output.
- Supplies the immediate word of two-word mvi instructions during the processor's second time step; stops on a halt opcode.

Parameters:
- ADDR_W, 6, program memory address width; depth = 2**ADDR_W words.
- DATA_W, 16, instruction/data word width; must match the processor DIN width.
- MVI_OP, 4'b0001, opcode (word bits [3:0]) that marks a two-word instruction.
- HALT_OP, 4'b1111, opcode that stops sequencing; never forwarded to the processor.
- WDOG_CYCLES, 8, Done timeout in cycles; used only with the optional feature.

Ports:
- Clock, in, 1, single clock, all state rising-edge.
- Resetn, in, 1, asynchronous active-low reset.
- Start, in, 1, one-cycle pulse; begins execution at address 0.
- LoadEn, in, 1, program memory write strobe.
- LoadAddr, in, ADDR_W, write address.
- LoadData, in, DATA_W, write data.
- Done, in, 1, processor completion flag, sampled at rising edge.
- DIN, out, DATA_W, registered word presented to the processor.
- Run, out, 1, registered processor enable.
- PC, out, ADDR_W, address of the current instruction.
- Busy, out, 1, high in ISSUE or EXEC.
- Halted, out, 1, high in HALTED.
- InstrCount, out, 16, retired-instruction counter, saturates at 16'hFFFF.
- Fault, out, 1, Done-timeout flag (optional feature).

Behaviour:
- Reset (async, Resetn=0):
  - State=IDLE; PC=0; DIN=0; Run=0; InstrCount=0; Fault=0; Busy=0; Halted=0.
  - Memory contents are not reset.
- Memory: register array, combinational read, synchronous write on LoadEn.
  - Writes are accepted only in IDLE or HALTED; they are ignored while Busy.
- States: IDLE, ISSUE, EXEC, HALTED (and FAULT with the optional feature).
- IDLE / HALTED:
  - Start=1 and LoadEn=0 -> PC=0, go to ISSUE.
  - Start together with LoadEn in the same cycle: the write happens and Start is ignored.
- ISSUE (one cycle):
  - If mem[PC][3:0]==HALT_OP -> Run=0, go to HALTED; InstrCount is unchanged.
  - Otherwise DIN=mem[PC] and Run=1 from the next edge, go to EXEC. The processor latches IR on the first EXEC edge.
- EXEC:
  - Run held at 1.
  - On the first EXEC cycle, if the latched opcode==MVI_OP, DIN=mem[PC+1 mod depth] from the next edge, so the immediate is on DIN during the processor's T1/T2.
  - For every other opcode, DIN holds the instruction word.
  - On an edge with Done=1:
    - PC += 1, or += 2 for mvi; modulo depth, wraps 63->0 at default.
    - InstrCount += 1 (saturating).
    - Go to ISSUE. Run stays 1 across the transition with no gap.
- Latency: 1-cycle ISSUE overhead per instruction.
  - mv: 3 cycles total.
  - mvi: 4 cycles total.
  - ALU ops: 5 cycles total.
- Wrap: mvi at address depth-1 takes its immediate from address 0; next PC is 1.
- Done seen outside EXEC is ignored.
- Reset mid-operation returns to IDLE immediately with Run=0.
- Start while Busy is ignored.

Optional Feature:
- Macro: PROG_SEQUENCER_WDOG_EN.
- Defined:
  - A cycle counter clears on entry to EXEC.
  - If WDOG_CYCLES cycles elapse in EXEC without Done -> go to FAULT; Run=0, Fault=1, PC frozen.
  - FAULT is left only by reset or Start; Start clears Fault and restarts at 0.
- Undefined:
  - No counter; EXEC waits indefinitely; Fault is tied to 0; FAULT state does not exist.

Test Plan:
- Load mem[0]=mvi R0 (16'h0001), mem[1]=16'h0005, mem[2]=HALT (16'h000F); pulse Start -> DIN=16'h0001 then 16'h0005 in EXEC; R0=5; PC 0->2; Halted=1; InstrCount=1; Run=0.
- Program: mvi R0,3; mvi R1,4; add R0,R1 (16'h0082); HALT -> R0=7; InstrCount=3; Run continuous from first ISSUE until HALTED.
- mvi placed at address 63 with immediate 16'h00AA at address 0 -> DIN=16'h00AA during EXEC; next PC=1.
- LoadEn pulsed while Busy with LoadData=16'hFFFF -> memory unchanged; program result unaffected. Start while Busy -> ignored.
- Resetn low during EXEC of add -> same cycle Run=0, PC=0, state IDLE; a later Start reruns the program correctly.
- With PROG_SEQUENCER_WDOG_EN: hold Done=0 -> Fault=1 and Run=0 exactly 8 cycles after EXEC entry; Start clears Fault and restarts at PC=0.
